// File: rtl/settings_report_writer.sv
`default_nettype none
// ============================================================================
// Module   : settings_report_writer
// Purpose  : Snapshots the live settings registers on a start request and
//            serialises them into the shared buffer RAM as a response frame:
//            one header word (pair count N), then N (command id, value) pairs.
//            cmd_sel = 0 dumps every setting; 1..5 dumps that single setting;
//            anything larger latches a sticky error until reset.
// Ports    : clk, rst (async active-high)
//            start, cmd_sel           - request pulse and selection
//            busy, done, error        - status (done is a one-cycle pulse)
//            frame_len                - word count of the last completed frame
//            buf_wr_en/addr/data      - buffer write port, held while stalled
//            buf_wr_ready             - write accepted when en & ready at clk
//            settings_*               - live settings values
// Revision : 1.0  initial release
// ============================================================================
module settings_report_writer #(
    parameter int ADDR_W       = 11,
    parameter int BASE_ADDR    = 0,
    parameter int NUM_SETTINGS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       cmd_sel,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] frame_len,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [31:0]       buf_wr_data,
    input  logic              buf_wr_ready,
    input  logic [31:0]       settings_max_row,
    input  logic [31:0]       settings_max_col,
    input  logic [31:0]       settings_data_min,
    input  logic [31:0]       settings_data_max,
    input  logic [31:0]       settings_countdown
);

    localparam int                CNT_W  = $clog2(NUM_SETTINGS + 1);
    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  C_NUM  = CNT_W'(NUM_SETTINGS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_HDR = 3'd1,
        S_WR_CMD = 3'd2,
        S_WR_VAL = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_pair;      // index of the pair being written
    logic [CNT_W-1:0] r_pairs;     // pair count N of the current frame
    logic [2:0]       r_sel;       // latched cmd_sel (validated to 0..5)
    logic [31:0]      r_snap_row;
    logic [31:0]      r_snap_col;
    logic [31:0]      r_snap_min;
    logic [31:0]      r_snap_max;
    logic [31:0]      r_snap_cd;

    logic             w_accept;
    logic             w_sel_ok;
    logic [CNT_W-1:0] w_start_pairs;
    logic [CNT_W-1:0] w_next_pair;
    logic [31:0]      w_cur_id;
    logic [31:0]      w_next_id;
    logic [31:0]      w_cur_val;

    // buf_wr_en is a register, so ready only gates state advance, never the strobe.
    assign w_accept      = buf_wr_en & buf_wr_ready;
    assign w_sel_ok      = (cmd_sel <= 32'd5);
    assign w_start_pairs = (cmd_sel == 32'd0) ? C_NUM : CNT_W'(1);
    assign w_next_pair   = r_pair + CNT_W'(1);
    assign w_cur_id      = (r_sel == 3'd0) ? 32'(r_pair) + 32'd1 : 32'(r_sel);
    assign w_next_id     = (r_sel == 3'd0) ? 32'(r_pair) + 32'd2 : 32'(r_sel);

    always_comb begin
        w_cur_val = 32'd0;
        case (w_cur_id)
            32'd1:   w_cur_val = r_snap_row;
            32'd2:   w_cur_val = r_snap_col;
            32'd3:   w_cur_val = r_snap_min;
            32'd4:   w_cur_val = r_snap_max;
            32'd5:   w_cur_val = r_snap_cd;
            default: w_cur_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pair      <= '0;
            r_pairs     <= '0;
            r_sel       <= 3'd0;
            r_snap_row  <= 32'd0;
            r_snap_col  <= 32'd0;
            r_snap_min  <= 32'd0;
            r_snap_max  <= 32'd0;
            r_snap_cd   <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_len   <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= C_BASE;
            buf_wr_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !error) begin
                        if (w_sel_ok) begin
                            r_snap_row  <= settings_max_row;
                            r_snap_col  <= settings_max_col;
                            r_snap_min  <= settings_data_min;
                            r_snap_max  <= settings_data_max;
                            r_snap_cd   <= settings_countdown;
                            r_sel       <= cmd_sel[2:0];
                            r_pair      <= '0;
                            r_pairs     <= w_start_pairs;
                            busy        <= 1'b1;
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= C_BASE;
                            buf_wr_data <= 32'(w_start_pairs);
                            r_state     <= S_WR_HDR;
                        end else begin
                            error   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_WR_HDR: begin
                    if (w_accept) begin
                        buf_wr_addr <= buf_wr_addr + ADDR_W'(1);
                        buf_wr_data <= w_cur_id;   // r_pair is 0 here
                        r_state     <= S_WR_CMD;
                    end
                end
                S_WR_CMD: begin
                    if (w_accept) begin
                        buf_wr_addr <= buf_wr_addr + ADDR_W'(1);
                        buf_wr_data <= w_cur_val;
                        r_state     <= S_WR_VAL;
                    end
                end
                S_WR_VAL: begin
                    if (w_accept) begin
                        r_pair <= w_next_pair;
                        if (w_next_pair == r_pairs) begin
                            buf_wr_en   <= 1'b0;
                            buf_wr_addr <= C_BASE;
                            buf_wr_data <= 32'd0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            // 1 + 2N words: header plus N pairs
                            frame_len   <= ADDR_W'({r_pairs, 1'b1});
                            r_state     <= S_DONE;
                        end else begin
                            buf_wr_addr <= buf_wr_addr + ADDR_W'(1);
                            buf_wr_data <= w_next_id;
                            r_state     <= S_WR_CMD;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    // Sticky until reset; all requests are ignored.
                    busy      <= 1'b0;
                    buf_wr_en <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_settings_report_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_settings_report_writer
// Purpose  : Scoreboard bench for settings_report_writer. Two instances run
//            in lockstep, one at BASE_ADDR 0 and one at 2046 (address wrap).
//            Expected writes are queued when a request is issued and popped
//            as each instance presents accepted writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_settings_report_writer;

    localparam int ADDR_W = 11;
    localparam int BASE1  = 2046;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       cmd_sel;
    logic              ready;
    logic [31:0]       s_row, s_col, s_min, s_max, s_cd;

    logic              busy0, done0, err0, en0;
    logic [ADDR_W-1:0] flen0, addr0;
    logic [31:0]       data0;
    logic              busy1, done1, err1, en1;
    logic [ADDR_W-1:0] flen1, addr1;
    logic [31:0]       data1;

    int n_checks = 0;
    int n_pass   = 0;
    int dcnt0    = 0;
    int dcnt1    = 0;

    logic [31:0] q0a[$], q0d[$], q1a[$], q1d[$];

    logic       toggle_mode = 1'b0;
    logic [3:0] ready_pat   = 4'b1001;  // bit idx: 1,0,0,1
    int         pat_idx     = 0;

    always #5 clk = ~clk;

    settings_report_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .NUM_SETTINGS(5)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cmd_sel(cmd_sel),
        .busy(busy0), .done(done0), .error(err0), .frame_len(flen0),
        .buf_wr_en(en0), .buf_wr_addr(addr0), .buf_wr_data(data0),
        .buf_wr_ready(ready),
        .settings_max_row(s_row), .settings_max_col(s_col),
        .settings_data_min(s_min), .settings_data_max(s_max),
        .settings_countdown(s_cd)
    );

    settings_report_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE1), .NUM_SETTINGS(5)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cmd_sel(cmd_sel),
        .busy(busy1), .done(done1), .error(err1), .frame_len(flen1),
        .buf_wr_en(en1), .buf_wr_addr(addr1), .buf_wr_data(data1),
        .buf_wr_ready(ready),
        .settings_max_row(s_row), .settings_max_col(s_col),
        .settings_data_min(s_min), .settings_data_max(s_max),
        .settings_countdown(s_cd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] model_val(input int id);
        case (id)
            1: return s_row;
            2: return s_col;
            3: return s_min;
            4: return s_max;
            5: return s_cd;
            default: return 32'd0;
        endcase
    endfunction

    // Expected frame for both instances, built from the settings at request time.
    task automatic push_exp(input int sel);
        int n;
        int id;
        n = (sel == 0) ? 5 : 1;
        for (int b = 0; b < 2; b++) begin
            int base;
            base = (b == 0) ? 0 : BASE1;
            for (int k = 0; k < 1 + 2 * n; k++) begin
                logic [31:0] a, d;
                a = 32'((base + k) % 2048);
                if (k == 0) d = 32'(n);
                else begin
                    id = (sel == 0) ? ((k - 1) / 2 + 1) : sel;
                    d  = (k % 2 == 1) ? 32'(id) : model_val(id);
                end
                if (b == 0) begin q0a.push_back(a); q0d.push_back(d); end
                else        begin q1a.push_back(a); q1d.push_back(d); end
            end
        end
    endtask

    // Ready driver: held high, or cycled 1,0,0,1 in toggle mode.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                ready   = ready_pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end else begin
                ready = 1'b1;
            end
        end
    end

    // Write monitors: every presented write must match the queue head,
    // including while stalled; the head is popped when ready accepts it.
    always @(negedge clk) begin
        if (!rst) begin
            if (done0) dcnt0++;
            if (en0) begin
                check("w0_extra_write", 32'(q0a.size() == 0), 32'd0);
                if (q0a.size() != 0) begin
                    check("w0_addr", 32'(addr0), q0a[0]);
                    check("w0_data", data0, q0d[0]);
                    if (ready) begin void'(q0a.pop_front()); void'(q0d.pop_front()); end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done1) dcnt1++;
            if (en1) begin
                check("w1_extra_write", 32'(q1a.size() == 0), 32'd0);
                if (q1a.size() != 0) begin
                    check("w1_addr", 32'(addr1), q1a[0]);
                    check("w1_data", data1, q1d[0]);
                    if (ready) begin void'(q1a.pop_front()); void'(q1d.pop_front()); end
                end
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_busy0",  32'(busy0), 0);
        check("rst_done0",  32'(done0), 0);
        check("rst_err0",   32'(err0), 0);
        check("rst_en0",    32'(en0), 0);
        check("rst_addr0",  32'(addr0), 0);
        check("rst_data0",  data0, 0);
        check("rst_flen0",  32'(flen0), 0);
        check("rst_addr1",  32'(addr1), 32'(BASE1));
        check("rst_en1",    32'(en1), 0);
        check("rst_err1",   32'(err1), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        q0a.delete(); q0d.delete(); q1a.delete(); q1d.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        @(posedge clk);
        #1;
        cmd_sel = 32'(sel);
        start   = 1'b1;
        @(posedge clk);          // start sampled here
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input int sel, input bit lat_check, input bit chg_row);
        int n, npairs, d0, d1;
        npairs = (sel == 0) ? 5 : 1;
        d0 = dcnt0;
        d1 = dcnt1;
        push_exp(sel);
        pulse_start(sel);
        if (chg_row) s_row = 32'd8;
        check("busy_after_start", 32'(busy0), 1);
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done0) break;
        end
        check("done_seen", 32'(done0), 1);
        if (lat_check) check("done_cycle", 32'(n), 32'(2 * npairs + 2));
        check("done1_aligned", 32'(done1), 1);
        check("busy_at_done", 32'(busy0), 0);
        check("frame_len0", 32'(flen0), 32'(2 * npairs + 1));
        check("frame_len1", 32'(flen1), 32'(2 * npairs + 1));
        @(negedge clk);
        check("done_one_cycle", 32'(done0), 0);
        check("q0_drained", 32'(q0a.size()), 0);
        check("q1_drained", 32'(q1a.size()), 0);
        check("done0_count", 32'(dcnt0 - d0), 1);
        check("done1_count", 32'(dcnt1 - d1), 1);
    endtask

    initial begin
        int d0;
        rst     = 1'b1;
        start   = 1'b0;
        cmd_sel = 32'd0;
        s_row = 32'd10; s_col = 32'd20; s_min = 32'hFFFFFF9C;
        s_max = 32'd65535; s_cd = 32'd12;
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;

        // Full dump, ready always high
        run_frame(0, 1'b1, 1'b0);
        // Single setting (data_max)
        run_frame(4, 1'b1, 1'b0);
        check("single_latency_done", 32'(dcnt0), 2);

        // Stalled full dump with max_row changing after start
        pat_idx     = 0;
        toggle_mode = 1'b1;
        run_frame(0, 1'b0, 1'b1);
        toggle_mode = 1'b0;
        s_row = 32'd10;

        // Invalid selection, sticky error
        d0 = dcnt0;
        pulse_start(6);
        repeat (5) @(negedge clk);
        check("err_set0", 32'(err0), 1);
        check("err_set1", 32'(err1), 1);
        check("err_busy", 32'(busy0), 0);
        check("err_en", 32'(en0), 0);
        pulse_start(0);
        repeat (20) @(negedge clk);
        check("err_ignore_busy", 32'(busy0), 0);
        check("err_still", 32'(err0), 1);
        check("err_no_done", 32'(dcnt0 - d0), 0);
        do_reset();
        run_frame(0, 1'b1, 1'b0);

        // Reset during the 5th write
        push_exp(0);
        pulse_start(0);
        for (int k = 0; k < 100 && q0a.size() > 7; k++) @(negedge clk);
        check("four_writes_done", 32'(q0a.size()), 7);
        d0 = dcnt0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        q0a.delete(); q0d.delete(); q1a.delete(); q1d.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("no_done_after_abort", 32'(dcnt0 - d0), 0);
        run_frame(0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/settings_report_writer.md
Name: settings_report_writer

Overview:
- Readback counterpart of the settings write path: snapshots the live settings registers and serialises them into the shared buffer RAM as a response frame that the host-link transmitter sends out.
- Frame layout: one header word, then one (command id, value) pair per setting.
- Command ids match the settings write path: 1=max_row, 2=max_col, 3=data_min, 4=data_max, 5=countdown.
- Dumps all settings or a single one, depending on cmd_sel.

Parameters:
- ADDR_W, 11, buffer RAM address width.
- BASE_ADDR, 0, buffer address of the header word.
- NUM_SETTINGS, 5, number of settings written in "all" mode.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request pulse
- cmd_sel  in  32  0=all settings, 1..5=single setting id; sampled with start
- busy  out  1  high while a frame is being written
- done  out  1  one-cycle pulse after the last word is accepted
- error  out  1  sticky; set on invalid cmd_sel
- frame_len  out  ADDR_W  word count of the last completed frame
- buf_wr_en  out  1  buffer write strobe
- buf_wr_addr  out  ADDR_W  buffer write address
- buf_wr_data  out  32  buffer write data
- buf_wr_ready  in  1  RAM port grant; a write is accepted on a clk edge where buf_wr_en and buf_wr_ready are both high
- settings_max_row, settings_max_col, settings_data_min, settings_data_max, settings_countdown  in  32 each  live settings values

Behaviour:
- Reset (asynchronous, rst=1):
  - state IDLE.
  - busy, done, error, buf_wr_en = 0.
  - buf_wr_addr = BASE_ADDR; buf_wr_data = 0; frame_len = 0; snapshot registers = 0.
- States: IDLE, WR_HDR, WR_CMD, WR_VAL, DONE, ERR.
- IDLE:
  - start=1 and error=0 with cmd_sel in 0..5:
    - Capture all five settings into the snapshot on the same edge.
    - Latch cmd_sel and set the pair counter to 0.
    - Go to WR_HDR; busy=1 from the next cycle.
  - start=1 with cmd_sel>5: set error, go to ERR, write nothing.
  - start while error=1: ignored; busy stays 0.
- Pair count N: NUM_SETTINGS if cmd_sel=0, else 1. frame_len (latched at DONE) = 1+2N, i.e. 11 in "all" mode and 3 in single mode.
- WR_HDR:
  - buf_wr_en=1, addr=BASE_ADDR, data=N.
  - Advance only when the write is accepted.
- WR_CMD:
  - Pair i writes to addr BASE_ADDR+1+2i.
  - Data is the command id: i+1 in "all" mode, otherwise the latched cmd_sel.
- WR_VAL:
  - addr = BASE_ADDR+2+2i, data = the snapshot value for that id, passed through unchanged (data_min stays two's complement, no sign handling).
  - After acceptance: increment i; if i=N go to DONE, else go to WR_CMD.
- Stall (buf_wr_ready=0): buf_wr_en, buf_wr_addr and buf_wr_data hold stable; state does not advance.
- Timing: buf_wr_en is driven from the state, so no combinational path exists from buf_wr_ready to buf_wr_en.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, frame_len updated, then IDLE.
- Latency with buf_wr_ready held at 1: start sampled at edge 0 -> writes accepted at edges 1..(1+2N) -> done high during the cycle after the last accepted edge. In "all" mode that is 11 writes, with done in cycle 12.
- Settings inputs changing mid-frame have no effect; the snapshot is used.
- start during busy is ignored.
- ERR: busy=0, buf_wr_en=0; error stays 1 until rst.
- Address arithmetic is modulo 2^ADDR_W: a frame that starts near the top of the RAM wraps to address 0.
- rst mid-frame: immediate return to reset values; a partial frame is left in the RAM and done is not pulsed.

Test Plan:
1. Settings row=10, col=20, min=32'hFFFFFF9C, max=65535, countdown=12; cmd_sel=0, start, ready=1 -> 11 writes at addr 0..10 with data 5,1,10,2,20,3,FFFFFF9C,4,65535,5,12; done pulses in cycle 12; frame_len=11.
2. cmd_sel=4 with data_max=65535 -> 3 writes (0:1, 1:4, 2:65535); frame_len=3; done once.
3. Full dump with buf_wr_ready toggling 1,0,0,1 repeatedly, and settings_max_row changed to 8 after start -> same 11-word image as scenario 1, max_row still reported as 10; addr/data never change while ready=0.
4. cmd_sel=6 -> error=1, no buf_wr_en, done=0; a further start with cmd_sel=0 -> still no writes, busy=0; after rst, error=0 and a dump succeeds.
5. BASE_ADDR=2046, cmd_sel=0 -> header at 2046, then 2047, then wrapping to 0..8.
6. Assert rst during the 5th write -> all outputs at reset values on the next sample; no done pulse; a new start then produces a full frame.
